// File: rtl/vme_slave_responder.sv
// vme_slave_responder
//   VMEbus A24 slave. Decodes cycles from a remote master, issues one
//   request/acknowledge transaction on the local bus, then answers with
//   DTACK* or BERR* and steers the data transceiver.
//
//   Optional feature: define VME_SLAVE_BERR_TIMEOUT_EN to answer BERR* when
//   the local bus does not respond within TIMEOUT_CYCLES clocks.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   vme_as, vme_ds[1:0]     asynchronous active-low strobes ([1]=DS1, [0]=DS0)
//   vme_lword, vme_write    active-low cycle qualifiers
//   vme_address_mod[5:0]    address modifier
//   vme_address[23:1]       A[23:1]
//   vme_dtack, vme_dtack_oe DTACK* level / active-low driver enable
//   vme_berr, vme_berr_oe   BERR* level / active-low driver enable
//   data_oe, data_dir       transceiver enable (active-low), 1=local->VME
//   local_request/_write/_address/_byte_enable   local bus request
//   local_ack, local_error  local bus completion
module vme_slave_responder #(
  parameter logic [23:0] BASE_ADDR      = 24'hF00000,
  parameter logic [23:0] ADDR_MASK      = 24'hF00000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vme_as,
  input  logic [1:0]  vme_ds,
  input  logic        vme_lword,
  input  logic        vme_write,
  input  logic [5:0]  vme_address_mod,
  input  logic [23:1] vme_address,
  output logic        vme_dtack,
  output logic        vme_dtack_oe,
  output logic        vme_berr,
  output logic        vme_berr_oe,
  output logic        data_oe,
  output logic        data_dir,
  output logic        local_request,
  output logic        local_write,
  output logic [23:0] local_address,
  output logic [3:0]  local_byte_enable,
  input  logic        local_ack,
  input  logic        local_error
);

  localparam logic DIR_OUT = 1'b1;
  localparam logic DIR_IN  = 1'b0;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255 for the 8-bit timeout counter");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_RESPOND = 3'd2,
    S_RELEASE = 3'd3,
    S_IGNORE  = 3'd4
  } state_t;

  state_t      state;
  logic        as_meta, as_sync;
  logic [1:0]  ds_meta, ds_sync;
  logic        dtack_pending;

  logic        am_ok, addr_ok, cycle_start, be_valid;
  logic [3:0]  be_dec;
  logic        timeout_hit;

`ifdef VME_SLAVE_BERR_TIMEOUT_EN
  logic [7:0]  timeout_count;
  assign timeout_hit = (timeout_count == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Address/qualifiers are taken straight from the bus at the decode edge;
  // the master holds them stable while its strobes are asserted.
  always_comb begin
    am_ok = (vme_address_mod == 6'h39) || (vme_address_mod == 6'h3A) ||
            (vme_address_mod == 6'h3D) || (vme_address_mod == 6'h3E);
    addr_ok     = (({vme_address, 1'b0} & ADDR_MASK) == BASE_ADDR);
    cycle_start = !as_sync && (ds_sync != 2'b11);
    be_dec      = '0;
    be_valid    = 1'b0;
    if (!vme_lword) begin
      if (ds_sync == 2'b00 && !vme_address[1]) begin
        be_dec   = '1;
        be_valid = 1'b1;
      end
    end else if (ds_sync != 2'b11) begin
      be_valid = 1'b1;
      if (!vme_address[1]) be_dec = {~ds_sync, 2'b00};
      else                 be_dec = {2'b00, ~ds_sync};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      as_meta           <= 1'b1;
      as_sync           <= 1'b1;
      ds_meta           <= '1;
      ds_sync           <= '1;
      state             <= S_IDLE;
      dtack_pending     <= 1'b0;
      vme_dtack         <= 1'b1;
      vme_dtack_oe      <= 1'b1;
      vme_berr          <= 1'b1;
      vme_berr_oe       <= 1'b1;
      data_oe           <= 1'b1;
      data_dir          <= DIR_IN;
      local_request     <= 1'b0;
      local_write       <= 1'b0;
      local_address     <= '0;
      local_byte_enable <= '0;
`ifdef VME_SLAVE_BERR_TIMEOUT_EN
      timeout_count     <= '0;
`endif
    end else begin
      as_meta <= vme_as;
      as_sync <= as_meta;
      ds_meta <= vme_ds;
      ds_sync <= ds_meta;

      unique case (state)
        S_IDLE: begin
          if (cycle_start) begin
            if (!(am_ok && addr_ok)) begin
              state <= S_IGNORE;
            end else if (!be_valid) begin
              state       <= S_RESPOND;
              vme_berr    <= 1'b0;
              vme_berr_oe <= 1'b0;
            end else begin
              state             <= S_ACCESS;
              local_request     <= 1'b1;
              local_write       <= !vme_write;
              local_address     <= {vme_address[23:2], 2'b00};
              local_byte_enable <= be_dec;
              data_oe           <= vme_write;   // enabled (low) for writes
              data_dir          <= DIR_IN;
`ifdef VME_SLAVE_BERR_TIMEOUT_EN
              timeout_count     <= '0;
`endif
            end
          end
        end

        S_ACCESS: begin
          if (as_sync) begin
            state         <= S_IDLE;
            local_request <= 1'b0;
            data_oe       <= 1'b1;
          end else if (local_error || timeout_hit) begin
            state         <= S_RESPOND;
            local_request <= 1'b0;
            vme_berr      <= 1'b0;
            vme_berr_oe   <= 1'b0;
          end else if (local_ack) begin
            // DTACK* waits one cycle so read data settles on the bus first.
            state         <= S_RESPOND;
            local_request <= 1'b0;
            dtack_pending <= 1'b1;
            if (!local_write) begin
              data_oe  <= 1'b0;
              data_dir <= DIR_OUT;
            end
          end
`ifdef VME_SLAVE_BERR_TIMEOUT_EN
          else begin
            timeout_count <= timeout_count + 8'd1;
          end
`endif
        end

        S_RESPOND: begin
          if (dtack_pending) begin
            dtack_pending <= 1'b0;
            vme_dtack     <= 1'b0;
            vme_dtack_oe  <= 1'b0;
          end else if (ds_sync == 2'b11) begin
            state     <= S_RELEASE;
            vme_dtack <= 1'b1;
            vme_berr  <= 1'b1;
          end
        end

        S_RELEASE: begin
          state        <= S_IDLE;
          vme_dtack_oe <= 1'b1;
          vme_berr_oe  <= 1'b1;
          data_oe      <= 1'b1;
          data_dir     <= DIR_IN;
        end

        S_IGNORE: begin
          if (as_sync) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vme_slave_responder.sv
// Directed testbench for vme_slave_responder.
module tb_vme_slave_responder;

  logic        clock;
  logic        reset;
  logic        vme_as;
  logic [1:0]  vme_ds;
  logic        vme_lword;
  logic        vme_write;
  logic [5:0]  vme_address_mod;
  logic [23:1] vme_address;
  logic        vme_dtack, vme_dtack_oe, vme_berr, vme_berr_oe;
  logic        data_oe, data_dir;
  logic        local_request, local_write;
  logic [23:0] local_address;
  logic [3:0]  local_byte_enable;
  logic        local_ack, local_error;

  int n_compared   = 0;
  int n_mismatched = 0;

  vme_slave_responder #(
    .BASE_ADDR      (24'hF00000),
    .ADDR_MASK      (24'hF00000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .vme_as            (vme_as),
    .vme_ds            (vme_ds),
    .vme_lword         (vme_lword),
    .vme_write         (vme_write),
    .vme_address_mod   (vme_address_mod),
    .vme_address       (vme_address),
    .vme_dtack         (vme_dtack),
    .vme_dtack_oe      (vme_dtack_oe),
    .vme_berr          (vme_berr),
    .vme_berr_oe       (vme_berr_oe),
    .data_oe           (data_oe),
    .data_dir          (data_dir),
    .local_request     (local_request),
    .local_write       (local_write),
    .local_address     (local_address),
    .local_byte_enable (local_byte_enable),
    .local_ack         (local_ack),
    .local_error       (local_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic start_cycle(input logic [5:0] am, input logic [23:0] addr,
                             input logic lword, input logic wr, input logic [1:0] ds);
    logic [23:0] a;
    a               = addr;
    vme_address_mod = am;
    vme_address     = a[23:1];
    vme_lword       = lword;
    vme_write       = wr;
    vme_ds          = ds;
    vme_as          = 1'b0;
  endtask

  task automatic end_cycle();
    vme_as = 1'b1;
    vme_ds = 2'b11;
  endtask

  initial begin
    reset = 1'b1;
    vme_as = 1'b1; vme_ds = 2'b11; vme_lword = 1'b1; vme_write = 1'b1;
    vme_address_mod = '0; vme_address = '0;
    local_ack = 1'b0; local_error = 1'b0;
    tick(3);

    // Reset state
    check("rst_dtack",    {31'd0, vme_dtack},    32'd1);
    check("rst_dtack_oe", {31'd0, vme_dtack_oe}, 32'd1);
    check("rst_berr",     {31'd0, vme_berr},     32'd1);
    check("rst_berr_oe",  {31'd0, vme_berr_oe},  32'd1);
    check("rst_data_oe",  {31'd0, data_oe},      32'd1);
    check("rst_data_dir", {31'd0, data_dir},     32'd0);
    check("rst_request",  {31'd0, local_request}, 32'd0);
    check("rst_address",  {8'd0, local_address}, 32'd0);
    check("rst_be",       {28'd0, local_byte_enable}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Longword write at F00010
    start_cycle(6'h3D, 24'hF00010, 1'b0, 1'b0, 2'b00);
    tick(2);
    check("lw_req_n1", {31'd0, local_request}, 32'd0);
    tick(1);
    check("lw_req_n2",   {31'd0, local_request}, 32'd1);
    check("lw_addr",     {8'd0, local_address}, 32'hF00010);
    check("lw_be",       {28'd0, local_byte_enable}, 32'hF);
    check("lw_write",    {31'd0, local_write}, 32'd1);
    check("lw_data_oe",  {31'd0, data_oe}, 32'd0);
    tick(2);
    local_ack = 1'b1;
    tick(1);
    local_ack = 1'b0;
    check("lw_req_drop",   {31'd0, local_request}, 32'd0);
    check("lw_dtack_wait", {31'd0, vme_dtack_oe}, 32'd1);
    tick(1);
    check("lw_dtack",    {31'd0, vme_dtack}, 32'd0);
    check("lw_dtack_oe", {31'd0, vme_dtack_oe}, 32'd0);
    check("lw_dir",      {31'd0, data_dir}, 32'd0);
    tick(2);
    check("lw_dtack_hold", {31'd0, vme_dtack}, 32'd0);
    end_cycle();
    tick(2);
    check("lw_dtack_k1", {31'd0, vme_dtack}, 32'd0);
    tick(1);
    check("lw_dtack_hi",    {31'd0, vme_dtack}, 32'd1);
    check("lw_dtack_oe_k2", {31'd0, vme_dtack_oe}, 32'd0);
    tick(1);
    check("lw_dtack_rel", {31'd0, vme_dtack_oe}, 32'd1);
    check("lw_data_rel",  {31'd0, data_oe}, 32'd1);
    tick(2);

    // Byte read at odd address F00003 (DS0 only)
    start_cycle(6'h39, 24'hF00003, 1'b1, 1'b1, 2'b10);
    tick(3);
    check("br_req",     {31'd0, local_request}, 32'd1);
    check("br_be",      {28'd0, local_byte_enable}, 32'h1);
    check("br_addr",    {8'd0, local_address}, 32'hF00000);
    check("br_write",   {31'd0, local_write}, 32'd0);
    check("br_data_oe", {31'd0, data_oe}, 32'd1);
    local_ack = 1'b1;
    tick(1);
    local_ack = 1'b0;
    check("br_dir_out",    {31'd0, data_dir}, 32'd1);
    check("br_data_oe_on", {31'd0, data_oe}, 32'd0);
    check("br_no_dtack",   {31'd0, vme_dtack_oe}, 32'd1);
    tick(1);
    check("br_dtack", {31'd0, vme_dtack}, 32'd0);
    end_cycle();
    tick(4);
    check("br_rel_oe",  {31'd0, vme_dtack_oe}, 32'd1);
    check("br_rel_dir", {31'd0, data_dir}, 32'd0);
    tick(2);

    // Word at A1=1, both DS -> lanes [1:0]
    start_cycle(6'h3E, 24'hF00006, 1'b1, 1'b1, 2'b00);
    tick(3);
    check("wd_be",   {28'd0, local_byte_enable}, 32'h3);
    check("wd_addr", {8'd0, local_address}, 32'hF00004);
    local_ack = 1'b1;
    tick(1);
    local_ack = 1'b0;
    end_cycle();
    tick(6);

    // Byte write, DS1 only at A1=0 -> lane [3]
    start_cycle(6'h3A, 24'hF00100, 1'b1, 1'b0, 2'b01);
    tick(3);
    check("bw_be",    {28'd0, local_byte_enable}, 32'h8);
    check("bw_write", {31'd0, local_write}, 32'd1);
    local_ack = 1'b1;
    tick(1);
    local_ack = 1'b0;
    end_cycle();
    tick(6);

    // Address mismatch
    start_cycle(6'h3D, 24'hE00000, 1'b0, 1'b1, 2'b00);
    tick(3);
    check("am_addr_req", {31'd0, local_request}, 32'd0);
    tick(3);
    check("am_addr_dtack", {31'd0, vme_dtack_oe}, 32'd1);
    check("am_addr_berr",  {31'd0, vme_berr_oe}, 32'd1);
    end_cycle();
    tick(4);

    // AM mismatch
    start_cycle(6'h29, 24'hF00000, 1'b0, 1'b1, 2'b00);
    tick(5);
    check("am_mod_req",  {31'd0, local_request}, 32'd0);
    check("am_mod_berr", {31'd0, vme_berr_oe}, 32'd1);
    end_cycle();
    tick(4);

    // ack and error together -> BERR*
    start_cycle(6'h3D, 24'hF00020, 1'b0, 1'b1, 2'b00);
    tick(3);
    check("ae_req", {31'd0, local_request}, 32'd1);
    local_ack = 1'b1; local_error = 1'b1;
    tick(1);
    local_ack = 1'b0; local_error = 1'b0;
    check("ae_berr",    {31'd0, vme_berr}, 32'd0);
    check("ae_berr_oe", {31'd0, vme_berr_oe}, 32'd0);
    check("ae_req_off", {31'd0, local_request}, 32'd0);
    tick(2);
    check("ae_no_dtack", {31'd0, vme_dtack_oe}, 32'd1);
    end_cycle();
    tick(3);
    check("ae_berr_hi",  {31'd0, vme_berr}, 32'd1);
    check("ae_berr_drv", {31'd0, vme_berr_oe}, 32'd0);
    tick(1);
    check("ae_berr_rel", {31'd0, vme_berr_oe}, 32'd1);
    tick(2);

    // Illegal longword at A1=1 -> BERR* without request
    start_cycle(6'h3D, 24'hF00002, 1'b0, 1'b1, 2'b00);
    tick(3);
    check("il_berr", {31'd0, vme_berr}, 32'd0);
    check("il_req",  {31'd0, local_request}, 32'd0);
    tick(1);
    check("il_req2", {31'd0, local_request}, 32'd0);
    end_cycle();
    tick(6);

    // Master abort during ACCESS
    start_cycle(6'h3D, 24'hF00040, 1'b0, 1'b0, 2'b00);
    tick(3);
    check("ab_req", {31'd0, local_request}, 32'd1);
    end_cycle();
    tick(2);
    check("ab_req_hold", {31'd0, local_request}, 32'd1);
    tick(1);
    check("ab_req_off", {31'd0, local_request}, 32'd0);
    tick(3);
    check("ab_no_dtack", {31'd0, vme_dtack_oe}, 32'd1);
    check("ab_data_oe",  {31'd0, data_oe}, 32'd1);
    tick(2);

    // Reset while in RESPOND
    start_cycle(6'h3D, 24'hF00080, 1'b0, 1'b1, 2'b00);
    tick(3);
    local_ack = 1'b1;
    tick(1);
    local_ack = 1'b0;
    tick(1);
    check("rr_dtack_pre", {31'd0, vme_dtack}, 32'd0);
    reset = 1'b1;
    end_cycle();
    tick(1);
    check("rr_dtack",    {31'd0, vme_dtack}, 32'd1);
    check("rr_dtack_oe", {31'd0, vme_dtack_oe}, 32'd1);
    check("rr_data_oe",  {31'd0, data_oe}, 32'd1);
    check("rr_data_dir", {31'd0, data_dir}, 32'd0);
    check("rr_address",  {8'd0, local_address}, 32'd0);
    reset = 1'b0;
    tick(5);
    check("rr_quiet", {31'd0, vme_dtack_oe}, 32'd1);

`ifdef VME_SLAVE_BERR_TIMEOUT_EN
    // No local response -> BERR* 16 cycles after request rises
    start_cycle(6'h3D, 24'hF00100, 1'b0, 1'b1, 2'b00);
    tick(3);
    check("to_req", {31'd0, local_request}, 32'd1);
    tick(15);
    check("to_wait", {31'd0, vme_berr}, 32'd1);
    tick(1);
    check("to_berr",    {31'd0, vme_berr}, 32'd0);
    check("to_req_off", {31'd0, local_request}, 32'd0);
    end_cycle();
    tick(6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
